layer_param_stream: RTL and testbench

Parametrised weight/bias store for one fully connected layer, generalising the fixed 10x30 output-layer constant block. Weights and biases are loaded at run time through a write port. On request, the block streams them one weight per beat, with a valid/ready handshake, to the layer MAC datapath. It sits between the parameter loader and the neuron MAC units.

---
 rtl/layer_param_stream.sv | 263 ++++++++++++++++++++++++++
 tb/tb_layer_param_stream.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_param_stream.sv
// layer_param_stream: run-time loadable weight/bias store for one fully
// connected layer. Parameters are written through a simple write port while
// idle and streamed on request, one weight per beat (row-major: input index
// fastest), over a valid/ready handshake towards the MAC datapath.
//
// Optional build macro: PARAM_PARITY_EN
//   When defined, every stored word carries an even-parity bit. This adds the
//   wr_par_flip input (test hook that corrupts the stored parity bit), and the
//   out_par_err / out_par_err_sticky outputs.
//
// NUM_IN and NUM_OUT are expected to be at least 2 so that the row/column
// index ports have a non-zero width.
module layer_param_stream #(
    parameter int DATA_W  = 8,
    parameter int NUM_IN  = 30,
    parameter int NUM_OUT = 10,
    parameter int ADDR_W  = $clog2(NUM_IN * NUM_OUT)
) (
    input  logic                       clk,
    input  logic                       rst,
    // write port
    input  logic                       wr_en,
    input  logic                       wr_is_bias,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_err,
    // stream control
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    // beat stream
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_weight,
    output logic [DATA_W-1:0]          out_bias,
    output logic [$clog2(NUM_OUT)-1:0] out_row,
    output logic [$clog2(NUM_IN)-1:0]  out_col,
    output logic                       out_last_col,
    output logic                       out_last
`ifdef PARAM_PARITY_EN
    ,
    input  logic                       wr_par_flip,
    output logic                       out_par_err,
    output logic                       out_par_err_sticky
`endif
);

    localparam int DEPTH = NUM_IN * NUM_OUT;
    localparam int ROW_W = $clog2(NUM_OUT);
    localparam int COL_W = $clog2(NUM_IN);

    // Range limits widened by one bit so that DEPTH itself is representable.
    localparam logic [ADDR_W:0]    W_LIMIT  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]    B_LIMIT  = (ADDR_W + 1)'(NUM_OUT);
    localparam logic [COL_W-1:0]   LAST_COL = COL_W'(NUM_IN - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW = ROW_W'(NUM_OUT - 1);
    localparam logic [ADDR_W-1:0]  IDX_ONE  = ADDR_W'(1);
    localparam logic [ROW_W-1:0]   ROW_ONE  = ROW_W'(1);
    localparam logic [COL_W-1:0]   COL_ONE  = COL_W'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] weight_mem [DEPTH];
    logic [DATA_W-1:0] bias_mem   [NUM_OUT];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;
    logic              last_col_q;
    logic              last_q;
    logic [DATA_W-1:0] weight_q;
    logic [DATA_W-1:0] bias_q;
    logic              wr_err_q, wr_err_d;

    logic              load_beat;
    logic [ADDR_W-1:0] nxt_idx;
    logic [ROW_W-1:0]  nxt_row;
    logic [COL_W-1:0]  nxt_col;
    logic              nxt_last_col;
    logic              nxt_last;

    logic              wr_in_range;
    logic              wr_allowed;
    logic              wr_commit;

    // Write qualification: only outside STREAM and only inside the target array.
    always_comb begin
        wr_in_range = wr_is_bias ? ({1'b0, wr_addr} < B_LIMIT)
                                 : ({1'b0, wr_addr} < W_LIMIT);
        wr_allowed  = (state_q != S_STREAM);
        wr_commit   = wr_en & wr_allowed & wr_in_range;
        wr_err_d    = wr_en & ~(wr_allowed & wr_in_range);
    end

    // Storage write port; arrays are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            if (wr_is_bias) begin
                bias_mem[wr_addr[ROW_W-1:0]] <= wr_data;
            end else begin
                weight_mem[wr_addr] <= wr_data;
            end
        end
    end

    // Coordinates of the beat that would be loaded next: (0,0) from IDLE,
    // otherwise the successor of the beat currently on the output.
    always_comb begin
        if (state_q == S_IDLE) begin
            nxt_idx = '0;
            nxt_row = '0;
            nxt_col = '0;
        end else begin
            nxt_idx = idx_q + IDX_ONE;
            if (col_q == LAST_COL) begin
                nxt_col = '0;
                nxt_row = row_q + ROW_ONE;
            end else begin
                nxt_col = col_q + COL_ONE;
                nxt_row = row_q;
            end
        end
        nxt_last_col = (nxt_col == LAST_COL);
        nxt_last     = nxt_last_col && (nxt_row == LAST_ROW);
    end

    // Next-state logic; abort wins over a simultaneous handshake.
    always_comb begin
        state_d   = state_q;
        load_beat = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_STREAM;
                    load_beat = 1'b1;
                end
            end
            S_STREAM: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (out_ready) begin
                    if (last_q) begin
                        state_d = S_DONE;
                    end else begin
                        load_beat = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and write-error pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Output beat registers: registered reads of both arrays, held under
    // backpressure because load_beat only fires on start or a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            last_col_q <= 1'b0;
            last_q     <= 1'b0;
            weight_q   <= '0;
            bias_q     <= '0;
        end else if (load_beat) begin
            idx_q      <= nxt_idx;
            row_q      <= nxt_row;
            col_q      <= nxt_col;
            last_col_q <= nxt_last_col;
            last_q     <= nxt_last;
            weight_q   <= weight_mem[nxt_idx];
            bias_q     <= bias_mem[nxt_row];
        end
    end

    assign busy         = (state_q == S_STREAM);
    assign done         = (state_q == S_DONE);
    assign out_valid    = busy;
    assign wr_err       = wr_err_q;
    assign out_weight   = weight_q;
    assign out_bias     = bias_q;
    assign out_row      = row_q;
    assign out_col      = col_q;
    assign out_last_col = last_col_q;
    assign out_last     = last_q;

`ifdef PARAM_PARITY_EN
    // ------------------------------------------------------------------
    // Parity protection: one even-parity bit beside every stored word.
    // ------------------------------------------------------------------
    logic weight_par_mem [DEPTH];
    logic bias_par_mem   [NUM_OUT];
    logic weight_par_q;
    logic bias_par_q;
    logic par_sticky_q;
    logic wr_par_bit;

    // Even parity: the stored bit makes the data+parity XOR zero; the flip
    // input deliberately corrupts it.
    assign wr_par_bit = (^wr_data) ^ wr_par_flip;

    // Parity storage write port, mirroring the data arrays.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            if (wr_is_bias) begin
                bias_par_mem[wr_addr[ROW_W-1:0]] <= wr_par_bit;
            end else begin
                weight_par_mem[wr_addr] <= wr_par_bit;
            end
        end
    end

    // Parity bits travel with the beat they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight_par_q <= 1'b0;
            bias_par_q   <= 1'b0;
        end else if (load_beat) begin
            weight_par_q <= weight_par_mem[nxt_idx];
            bias_par_q   <= bias_par_mem[nxt_row];
        end
    end

    assign out_par_err = out_valid & ((^{weight_par_q, weight_q}) | (^{bias_par_q, bias_q}));

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_sticky_q <= 1'b0;
        end else if (out_par_err) begin
            par_sticky_q <= 1'b1;
        end
    end

    assign out_par_err_sticky = par_sticky_q;
`endif

endmodule

// File: tb/tb_layer_param_stream.sv
// Scoreboard bench for layer_param_stream (default parameters).
// Stimulus pushes every expected beat into a queue; a negedge monitor pops and
// compares on each handshake. Control signals are checked from the stimulus.
module tb_layer_param_stream;

    localparam int DATA_W  = 8;
    localparam int NUM_IN  = 30;
    localparam int NUM_OUT = 10;
    localparam int DEPTH   = NUM_IN * NUM_OUT;
    localparam int ADDR_W  = 9;

    typedef struct packed {
        logic [7:0] w;
        logic [7:0] b;
        logic [3:0] row;
        logic [4:0] col;
        logic       lc;
        logic       last;
        logic       perr;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic              wr_is_bias = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [7:0]        wr_data = '0;
    logic              wr_err;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [7:0]        out_weight;
    logic [7:0]        out_bias;
    logic [3:0]        out_row;
    logic [4:0]        out_col;
    logic              out_last_col;
    logic              out_last;
    logic              wr_par_flip = 1'b0;
    logic              par_err_s;
    logic              par_sticky_s;

    layer_param_stream #(
        .DATA_W (DATA_W),
        .NUM_IN (NUM_IN),
        .NUM_OUT(NUM_OUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_is_bias  (wr_is_bias),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_err      (wr_err),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_weight  (out_weight),
        .out_bias    (out_bias),
        .out_row     (out_row),
        .out_col     (out_col),
        .out_last_col(out_last_col),
        .out_last    (out_last)
`ifdef PARAM_PARITY_EN
        ,
        .wr_par_flip       (wr_par_flip),
        .out_par_err       (par_err_s),
        .out_par_err_sticky(par_sticky_s)
`endif
    );

`ifndef PARAM_PARITY_EN
    assign par_err_s    = 1'b0;
    assign par_sticky_s = 1'b0;
`endif

    always #5 clk = ~clk;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_pass = 0;
    int    beat_cnt = 0;
    int    last_beat_cyc = -10;
    beat_t sb_q[$];
    logic [7:0] wref [DEPTH];
    logic [7:0] bref [NUM_OUT];
    bit         wflip [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the first n beats of a stream as predicted from the bench's own copy of storage.
    task automatic push_stream(input int n);
        beat_t e;
        for (int k = 0; k < n; k++) begin
            e.w    = wref[k];
            e.b    = bref[k / NUM_IN];
            e.row  = 4'(k / NUM_IN);
            e.col  = 5'(k % NUM_IN);
            e.lc   = ((k % NUM_IN) == NUM_IN - 1);
            e.last = (k == DEPTH - 1);
            e.perr = wflip[k];
            sb_q.push_back(e);
        end
    endtask

    task automatic do_write(input bit isb, input int addr, input logic [7:0] data, input bit exp_err);
        wr_en      = 1'b1;
        wr_is_bias = isb;
        wr_addr    = ADDR_W'(addr);
        wr_data    = data;
        tick();
        wr_en      = 1'b0;
        chk("wr_err", {31'd0, wr_err}, {31'd0, exp_err});
        if (!exp_err) begin
            if (isb) bref[addr] = data;
            else begin
                wref[addr]  = data;
                wflip[addr] = wr_par_flip;
            end
        end
    endtask

    task automatic pulse_start();
        beat_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Bounded wait for the done pulse, then check its timing and width.
    task automatic wait_done();
        bit seen = 1'b0;
        int n = 0;
        while (n < 400 && !seen) begin
            tick();
            n++;
            if (done) seen = 1'b1;
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            chk("done_latency", cyc - last_beat_cyc, 32'd1);
            chk("busy_in_done", {31'd0, busy}, 32'd0);
            chk("valid_in_done", {31'd0, out_valid}, 32'd0);
            tick();
            chk("done_width", {31'd0, done}, 32'd0);
        end
        chk("sb_empty", sb_q.size(), 32'd0);
    endtask

    // Monitor: compare every accepted beat against the scoreboard head.
    always @(negedge clk) begin
        beat_t exp_b;
        beat_t act_b;
        if (!rst && out_valid && out_ready) begin
            beat_cnt++;
            act_b = {out_weight, out_bias, out_row, out_col, out_last_col, out_last, par_err_s};
            if (sb_q.size() == 0) begin
                chk("unexpected_beat", {4'd0, act_b}, 32'd0);
            end else begin
                exp_b = sb_q.pop_front();
                chk("beat", {4'd0, act_b}, {4'd0, exp_b});
            end
            if (out_last) last_beat_cyc = cyc;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 40000", cyc);
        $fatal(1, "watchdog");
    end

    logic [31:0] snap;

    initial begin
        for (int k = 0; k < DEPTH; k++) wflip[k] = 1'b0;

        // Reset state
        ticks(3);
        chk("rst_ctrl", {26'd0, busy, done, wr_err, out_valid, out_last_col, out_last}, 32'd0);
        chk("rst_data", {out_weight, out_bias, out_row, out_col, 2'd0, par_sticky_s}, 32'd0);
        rst = 1'b0;
        tick();

        // Load pattern: weight[k] = k-150, bias[o] = -o
        for (int k = 0; k < DEPTH; k++) do_write(1'b0, k, 8'(k - 150), 1'b0);
        for (int o = 0; o < NUM_OUT; o++) do_write(1'b1, o, 8'(-o), 1'b0);
        chk("idle_no_valid", {31'd0, out_valid}, 32'd0);

        // Stream 1: latency, spot beat, backpressure, start while busy
        push_stream(DEPTH);
        pulse_start();
        chk("first_beat", {busy, out_valid, out_row, out_col}, {1'b1, 1'b1, 4'd0, 5'd0});
        ticks(31);
        chk("beat31", {out_weight, out_bias, out_row, out_col}, {8'h89, 8'hFF, 4'd1, 5'd1});
        ticks(96);
        chk("bp_pos", {out_row, out_col}, {4'd4, 5'd7});
        out_ready = 1'b0;
        snap = {out_valid, out_weight, out_bias, out_row, out_col, out_last_col, out_last};
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold", {out_valid, out_weight, out_bias, out_row, out_col, out_last_col, out_last}, snap);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_resume", {out_row, out_col}, {4'd4, 5'd8});
        ticks(27);
        chk("busy_start_pos", {out_row, out_col}, {4'd5, 5'd5});
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("no_restart", {busy, out_row, out_col}, {1'b1, 4'd5, 5'd6});
        wait_done();
        chk("beat_count1", beat_cnt, DEPTH);

        // Illegal writes: out of range and mid-stream
        do_write(1'b0, 300, 8'h11, 1'b1);
        do_write(1'b1, 10, 8'h22, 1'b1);
        push_stream(DEPTH);
        pulse_start();
        ticks(10);
        do_write(1'b0, 3, 8'h55, 1'b1);
        do_write(1'b1, 0, 8'h66, 1'b1);
        wait_done();
        push_stream(DEPTH);
        pulse_start();
        wait_done();
        chk("beat_count_restream", beat_cnt, DEPTH);

        // Same-cycle write and start: a later beat sees the new value
        wref[5] = 8'hA5;
        push_stream(DEPTH);
        wr_en = 1'b1; wr_is_bias = 1'b0; wr_addr = 9'd5; wr_data = 8'hA5;
        pulse_start();
        wr_en = 1'b0;
        chk("wr_start_err", {31'd0, wr_err}, 32'd0);
        wait_done();

        // Same-cycle write and start on the first beat: old value streamed first
        push_stream(DEPTH);
        wref[0] = 8'h3C;
        wr_en = 1'b1; wr_is_bias = 1'b0; wr_addr = 9'd0; wr_data = 8'h3C;
        pulse_start();
        wr_en = 1'b0;
        wait_done();

        // Abort together with a handshake at (2,0)
        push_stream(61);
        pulse_start();
        ticks(60);
        chk("abort_pos", {out_row, out_col}, {4'd2, 5'd0});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_stop", {30'd0, out_valid, busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_done", {31'd0, done}, 32'd0);
            tick();
        end
        chk("abort_beats", beat_cnt, 32'd61);
        chk("abort_sb_empty", sb_q.size(), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle_noop", {30'd0, busy, out_valid}, 32'd0);
        push_stream(DEPTH);
        pulse_start();
        chk("restart_pos", {out_valid, out_row, out_col}, {1'b1, 4'd0, 5'd0});
        wait_done();
        chk("beat_count_after_abort", beat_cnt, DEPTH);

`ifdef PARAM_PARITY_EN
        // Corrupt the parity of weight[37] (beat (1,7))
        chk("sticky_pre", {31'd0, par_sticky_s}, 32'd0);
        wr_par_flip = 1'b1;
        do_write(1'b0, 37, wref[37], 1'b0);
        wr_par_flip = 1'b0;
        push_stream(DEPTH);
        pulse_start();
        ticks(36);
        chk("sticky_before_bad", {31'd0, par_sticky_s}, 32'd0);
        wait_done();
        chk("sticky_post", {31'd0, par_sticky_s}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
